// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared bank-count constants and one-hot helper for the bank arbiter and return router
package arb_pkg;

  localparam int NUM_BANKS  = 16;
  localparam int BANK_IDX_W = 4;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_IDX_W-1:0] idx);
    bank_onehot      = '0;
    bank_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/ret_fifo.sv
// rtl/ret_fifo.sv - generic in-order FIFO with occupancy count and combinational head read
module ret_fifo #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign count   = count_q;

  // Storage carries no reset; the empty flag masks stale contents downstream.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/read_return_router.sv
// rtl/read_return_router.sv - routes in-order read responses back to 16 bank queues
// Optional same-cycle bypass of an empty FIFO: define READ_RETURN_BYPASS_EN.
module read_return_router
  import arb_pkg::*;
#(
  parameter int REQ_SIZE = 32,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BANK_IDX_W-1:0]      in_bank,
  input  logic [REQ_SIZE-1:0]        in_data,
  output logic [NUM_BANKS-1:0]       out_valid,
  output logic [REQ_SIZE-1:0]        out_data,
  input  logic [NUM_BANKS-1:0]       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  typedef struct packed {
    logic [BANK_IDX_W-1:0] bank;
    logic [REQ_SIZE-1:0]   data;
  } ret_entry_t;

  ret_entry_t wr_entry;
  ret_entry_t head;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;

  assign wr_entry = '{bank: in_bank, data: in_data};
  assign in_ready = !fifo_full;
  // Only the head's own bank ready matters; strict order is intended.
  assign fifo_pop = !fifo_empty && out_ready[head.bank];

`ifdef READ_RETURN_BYPASS_EN
  logic bypass_live;
  logic bypass_take;

  assign bypass_live = fifo_empty && in_valid;
  assign bypass_take = bypass_live && out_ready[in_bank];
  assign fifo_push   = in_valid && in_ready && !bypass_take;

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    if (!fifo_empty) begin
      out_valid = bank_onehot(head.bank);
      out_data  = head.data;
    end else if (bypass_live) begin
      out_valid = bank_onehot(in_bank);
      out_data  = in_data;
    end
  end
`else
  assign fifo_push = in_valid && in_ready;

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    if (!fifo_empty) begin
      out_valid = bank_onehot(head.bank);
      out_data  = head.data;
    end
  end
`endif

  ret_fifo #(
    .WIDTH ($bits(ret_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (wr_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
